soc_ar_addr_decoder: RTL and testbench

- Registered read-address decode stage placed directly upstream of the SoC AXI crossbar master port.
- Accepts AR requests and matches each address against the fixed SoC address map.
- Mapped requests are forwarded with a slave-select index to the crossbar.
- Unmapped requests are absorbed locally and answered with a DECERR read burst of the correct length, so the crossbar never sees an illegal address.

---
 rtl/soc_ar_addr_decoder_if.sv | 50 +++++
 rtl/soc_ar_addr_decoder.sv | 151 +++++++++++++++
 tb/tb_soc_ar_addr_decoder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_ar_addr_decoder_if.sv
// ---------------------------------------------------------------------------
// soc_ar_addr_decoder_if : AR request, forwarded AR and DECERR R bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface soc_ar_addr_decoder_if #(
  parameter int IdWidth   = 5,
  parameter int AddrWidth = 64,
  parameter int SelWidth  = 4
);
  logic                 s_ar_valid_i;
  logic                 s_ar_ready_o;
  logic [IdWidth-1:0]   s_ar_id_i;
  logic [AddrWidth-1:0] s_ar_addr_i;
  logic [7:0]           s_ar_len_i;

  logic                 m_ar_valid_o;
  logic                 m_ar_ready_i;
  logic [IdWidth-1:0]   m_ar_id_o;
  logic [AddrWidth-1:0] m_ar_addr_o;
  logic [7:0]           m_ar_len_o;
  logic [SelWidth-1:0]  m_ar_sel_o;

  logic                 err_r_valid_o;
  logic                 err_r_ready_i;
  logic [IdWidth-1:0]   err_r_id_o;
  logic [1:0]           err_r_resp_o;
  logic                 err_r_last_o;

  // Decoder side.
  modport slave (
    input  s_ar_valid_i, s_ar_id_i, s_ar_addr_i, s_ar_len_i,
    input  m_ar_ready_i, err_r_ready_i,
    output s_ar_ready_o,
    output m_ar_valid_o, m_ar_id_o, m_ar_addr_o, m_ar_len_o, m_ar_sel_o,
    output err_r_valid_o, err_r_id_o, err_r_resp_o, err_r_last_o
  );

  // Environment side (upstream master, crossbar and R merge).
  modport master (
    output s_ar_valid_i, s_ar_id_i, s_ar_addr_i, s_ar_len_i,
    output m_ar_ready_i, err_r_ready_i,
    input  s_ar_ready_o,
    input  m_ar_valid_o, m_ar_id_o, m_ar_addr_o, m_ar_len_o, m_ar_sel_o,
    input  err_r_valid_o, err_r_id_o, err_r_resp_o, err_r_last_o
  );
endinterface

`default_nettype wire

// File: rtl/soc_ar_addr_decoder.sv
// ---------------------------------------------------------------------------
// soc_ar_addr_decoder : registered AR decode stage with local DECERR bursts
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module soc_ar_addr_decoder #(
  parameter int IdWidth     = 5,
  parameter int AddrWidth   = 64,
  parameter int SelWidth    = 4,
  parameter int ErrCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  soc_ar_addr_decoder_if.slave    bus,
  output logic [ErrCntWidth-1:0]  err_cnt_o
);

  localparam int NumRegions = 14;

  localparam logic [63:0] RegionBase [NumRegions] = '{
    64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000,
    64'h1000_0000, 64'h1C00_0000, 64'h1A10_0000, 64'h1800_0000,
    64'h2000_0000, 64'h3000_0000, 64'h4000_0000, 64'h1040_0000,
    64'h6000_0000, 64'h8000_0000
  };

  localparam logic [63:0] RegionSize [NumRegions] = '{
    64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF,
    64'h0040_0000, 64'h0008_0000, 64'h0012_3000, 64'h0000_1000,
    64'h0080_0000, 64'h0001_0000, 64'h0000_1000, 64'h0010_0000,
    64'h0000_1000, 64'h2000_0000
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ERR  = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    s_ar_ready_q;
  logic                    m_ar_valid_q;
  logic                    err_valid_q;
  logic                    err_last_q;
  logic [IdWidth-1:0]      id_q;
  logic [AddrWidth-1:0]    addr_q;
  logic [7:0]              len_q;
  logic [SelWidth-1:0]     sel_q;
  logic [7:0]              beat_q;
  logic [ErrCntWidth-1:0]  err_cnt_q;

  logic [NumRegions-1:0]   hit_d;
  logic [SelWidth-1:0]     sel_d;
  logic [63:0]             addr_d;

  assign addr_d = 64'(bus.s_ar_addr_i);

  for (genvar g = 0; g < NumRegions; g++) begin : g_region
    assign hit_d[g] = (addr_d >= RegionBase[g]) &&
                      (addr_d <  RegionBase[g] + RegionSize[g]);
  end

  // Regions are disjoint, so at most one bit of hit_d is set.
  always_comb begin
    sel_d = '0;
    for (int k = 0; k < NumRegions; k++) begin
      if (hit_d[k]) sel_d = SelWidth'(k);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      s_ar_ready_q <= 1'b1;
      m_ar_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_last_q   <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      sel_q        <= '0;
      beat_q       <= '0;
      err_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.s_ar_valid_i) begin
            id_q         <= bus.s_ar_id_i;
            addr_q       <= bus.s_ar_addr_i;
            len_q        <= bus.s_ar_len_i;
            s_ar_ready_q <= 1'b0;
            if (|hit_d) begin
              sel_q        <= sel_d;
              m_ar_valid_q <= 1'b1;
              state_q      <= FWD;
            end else begin
              beat_q      <= bus.s_ar_len_i;
              err_last_q  <= (bus.s_ar_len_i == 8'd0);
              err_valid_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
              state_q     <= ERR;
            end
          end
        end
        FWD: begin
          if (bus.m_ar_ready_i) begin
            m_ar_valid_q <= 1'b0;
            s_ar_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        ERR: begin
          if (bus.err_r_ready_i) begin
            if (err_last_q) begin
              err_valid_q  <= 1'b0;
              err_last_q   <= 1'b0;
              s_ar_ready_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              beat_q     <= beat_q - 8'd1;
              err_last_q <= (beat_q == 8'd1);
            end
          end
        end
        default: begin
          s_ar_ready_q <= 1'b1;
          m_ar_valid_q <= 1'b0;
          err_valid_q  <= 1'b0;
          err_last_q   <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_ar_ready_o  = s_ar_ready_q;
  assign bus.m_ar_valid_o  = m_ar_valid_q;
  assign bus.m_ar_id_o     = id_q;
  assign bus.m_ar_addr_o   = addr_q;
  assign bus.m_ar_len_o    = len_q;
  assign bus.m_ar_sel_o    = sel_q;
  assign bus.err_r_valid_o = err_valid_q;
  assign bus.err_r_id_o    = id_q;
  assign bus.err_r_resp_o  = {2{err_valid_q}};
  assign bus.err_r_last_o  = err_last_q;
  assign err_cnt_o         = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_soc_ar_addr_decoder.sv
// ---------------------------------------------------------------------------
// tb_soc_ar_addr_decoder : scoreboard bench for soc_ar_addr_decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_soc_ar_addr_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soc_ar_addr_decoder_if #(.IdWidth(5), .AddrWidth(64), .SelWidth(4)) bus ();
  soc_ar_addr_decoder_if #(.IdWidth(5), .AddrWidth(64), .SelWidth(4)) bus2 ();
  logic [15:0] err_cnt;
  logic [3:0]  err_cnt2;

  soc_ar_addr_decoder dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .err_cnt_o (err_cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  soc_ar_addr_decoder #(.ErrCntWidth(4)) dut_sat (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus2),
    .err_cnt_o (err_cnt2)
  );

  typedef struct {
    bit          is_err;
    logic [4:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  sel;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference of the address map: [start, end) pairs.
  function automatic int ref_decode(input logic [63:0] a);
    if (a < 64'h1000)                               return 0;
    if (a >= 64'h0001_0000 && a < 64'h0002_0000)    return 1;
    if (a >= 64'h0200_0000 && a < 64'h020C_0000)    return 2;
    if (a >= 64'h0C00_0000 && a < 64'h0FFF_FFFF)    return 3;
    if (a >= 64'h1000_0000 && a < 64'h1040_0000)    return 4;
    if (a >= 64'h1C00_0000 && a < 64'h1C08_0000)    return 5;
    if (a >= 64'h1A10_0000 && a < 64'h1A22_3000)    return 6;
    if (a >= 64'h1800_0000 && a < 64'h1800_1000)    return 7;
    if (a >= 64'h2000_0000 && a < 64'h2080_0000)    return 8;
    if (a >= 64'h3000_0000 && a < 64'h3001_0000)    return 9;
    if (a >= 64'h4000_0000 && a < 64'h4000_1000)    return 10;
    if (a >= 64'h1040_0000 && a < 64'h1050_0000)    return 11;
    if (a >= 64'h6000_0000 && a < 64'h6000_1000)    return 12;
    if (a >= 64'h8000_0000 && a < 64'hA000_0000)    return 13;
    return -1;
  endfunction

  task automatic send(input logic [4:0] id, input logic [63:0] addr, input logic [7:0] len);
    int   s;
    int   waited;
    exp_t e;
    waited = 0;
    while (bus.s_ar_ready_o !== 1'b1 && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 2000) chk("send_ready_timeout", 64'(bus.s_ar_ready_o), 64'd1);
    s = ref_decode(addr);
    e.id = id; e.addr = addr; e.len = len; e.sel = '0; e.last = 1'b0;
    if (s >= 0) begin
      e.is_err = 1'b0;
      e.sel    = 4'(s);
      sb.push_back(e);
    end else begin
      e.is_err = 1'b1;
      for (int b = 0; b <= int'(len); b++) begin
        e.last = (b == int'(len));
        sb.push_back(e);
      end
      exp_errs++;
    end
    bus.s_ar_id_i    = id;
    bus.s_ar_addr_i  = addr;
    bus.s_ar_len_i   = len;
    bus.s_ar_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.s_ar_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || bus.s_ar_ready_o !== 1'b1) && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("drain_timeout", 64'(waited < 2000), 64'd1);
  endtask

  // Monitor: sample mid-cycle, pop one expectation per completed handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_exclusive", 64'(bus.m_ar_valid_o & bus.err_r_valid_o), 64'd0);
      if (bus.m_ar_valid_o && bus.m_ar_ready_i) begin
        chk("fwd_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("fwd_kind", 64'(mon_e.is_err), 64'd0);
          chk("fwd_id",   64'(bus.m_ar_id_o),   64'(mon_e.id));
          chk("fwd_addr", bus.m_ar_addr_o,      mon_e.addr);
          chk("fwd_len",  64'(bus.m_ar_len_o),  64'(mon_e.len));
          chk("fwd_sel",  64'(bus.m_ar_sel_o),  64'(mon_e.sel));
        end
      end
      if (bus.err_r_valid_o && bus.err_r_ready_i) begin
        chk("err_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("err_kind", 64'(mon_e.is_err),      64'd1);
          chk("err_id",   64'(bus.err_r_id_o),    64'(mon_e.id));
          chk("err_resp", 64'(bus.err_r_resp_o),  64'd3);
          chk("err_last", 64'(bus.err_r_last_o),  64'(mon_e.last));
        end
      end
    end
  end

  initial begin
    int waited;
    bus.s_ar_valid_i = 1'b0; bus.s_ar_id_i = '0; bus.s_ar_addr_i = '0; bus.s_ar_len_i = '0;
    bus.m_ar_ready_i = 1'b1; bus.err_r_ready_i = 1'b1;
    bus2.s_ar_valid_i = 1'b0; bus2.s_ar_id_i = '0; bus2.s_ar_addr_i = 64'h5000_0000;
    bus2.s_ar_len_i = '0; bus2.m_ar_ready_i = 1'b1; bus2.err_r_ready_i = 1'b1;

    // Reset state
    #12;
    chk("rst_s_ready",   64'(bus.s_ar_ready_o),  64'd1);
    chk("rst_m_valid",   64'(bus.m_ar_valid_o),  64'd0);
    chk("rst_err_valid", 64'(bus.err_r_valid_o), 64'd0);
    chk("rst_err_resp",  64'(bus.err_r_resp_o),  64'd0);
    chk("rst_err_cnt",   64'(err_cnt),           64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Forward with 1-cycle latency
    send(5'd3, 64'h8000_0000, 8'd7);
    chk("lat_m_valid", 64'(bus.m_ar_valid_o), 64'd1);
    chk("lat_s_ready", 64'(bus.s_ar_ready_o), 64'd0);
    wait_idle();

    // Map boundaries and a 64-bit-only miss
    send(5'd1, 64'h1A22_2FFF, 8'd0);
    send(5'd2, 64'h1A22_3000, 8'd1);
    send(5'd4, 64'h1040_0000, 8'd2);
    send(5'd5, 64'h0FFF_FFFF, 8'd0);
    send(5'd6, 64'h0FFF_FFFE, 8'd0);
    send(5'd7, 64'h1_8000_0000, 8'd0);
    send(5'd8, 64'h0000_0FFF, 8'd4);
    wait_idle();
    chk("cnt_after_boundary", 64'(err_cnt), 64'(exp_errs));

    // Four-beat DECERR burst
    send(5'd9, 64'h5000_0000, 8'd3);
    wait_idle();
    chk("cnt_after_burst", 64'(err_cnt), 64'(exp_errs));

    // Single beat held under back-pressure
    bus.err_r_ready_i = 1'b0;
    send(5'd17, 64'h7000_0000, 8'd0);
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", 64'(bus.err_r_valid_o), 64'd1);
      chk("hold_last",  64'(bus.err_r_last_o),  64'd1);
      chk("hold_id",    64'(bus.err_r_id_o),    64'd17);
      @(posedge clk); #1;
    end
    bus.err_r_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("hold_back_idle",  64'(bus.s_ar_ready_o),  64'd1);
    chk("hold_valid_drop", 64'(bus.err_r_valid_o), 64'd0);
    wait_idle();

    // Long burst interrupted by reset
    send(5'd21, 64'hF000_0000, 8'd255);
    repeat (100) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_err_valid", 64'(bus.err_r_valid_o), 64'd0);
    chk("mid_rst_err_last",  64'(bus.err_r_last_o),  64'd0);
    chk("mid_rst_m_valid",   64'(bus.m_ar_valid_o),  64'd0);
    chk("mid_rst_err_cnt",   64'(err_cnt),           64'd0);
    chk("mid_rst_s_ready",   64'(bus.s_ar_ready_o),  64'd1);
    chk("mid_rst_beats_left", 64'(sb.size()),        64'd156);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_errs = 0;
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_resume", 64'(bus.err_r_valid_o), 64'd0);
    end
    send(5'd2, 64'h4000_0800, 8'd1);
    wait_idle();

    // Forward stalled by crossbar
    bus.m_ar_ready_i = 1'b0;
    send(5'd12, 64'h0, 8'd15);
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid",   64'(bus.m_ar_valid_o), 64'd1);
      chk("stall_s_ready", 64'(bus.s_ar_ready_o), 64'd0);
      chk("stall_addr",    bus.m_ar_addr_o,       64'd0);
      chk("stall_id",      64'(bus.m_ar_id_o),    64'd12);
      chk("stall_len",     64'(bus.m_ar_len_o),   64'd15);
      chk("stall_sel",     64'(bus.m_ar_sel_o),   64'd0);
      @(posedge clk); #1;
    end
    bus.m_ar_ready_i = 1'b1;
    wait_idle();
    chk("cnt_after_reset", 64'(err_cnt), 64'(exp_errs));

    // Saturating counter on the narrow instance
    for (int m = 1; m <= 20; m++) begin
      waited = 0;
      while (bus2.s_ar_ready_o !== 1'b1 && waited < 100) begin
        @(posedge clk); #1;
        waited++;
      end
      bus2.s_ar_valid_i = 1'b1;
      @(posedge clk); #1;
      bus2.s_ar_valid_i = 1'b0;
      if (m == 14) chk("sat_cnt_14", 64'(err_cnt2), 64'd14);
      if (m == 15) chk("sat_cnt_15", 64'(err_cnt2), 64'd15);
      if (m == 20) chk("sat_cnt_20", 64'(err_cnt2), 64'd15);
    end
    repeat (3) @(posedge clk); #1;

    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
